// File: rtl/cq_poller.sv
// cq_poller: walks a completion queue over AXI, hands each new entry to the host side and
// rings the CQ head doorbell. Optional poll backoff is enabled by defining CQ_POLL_BACKOFF_EN.
module cq_poller #(
    parameter logic [31:0] CQ_BASE    = 32'h20400,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] DB_ADDR    = 32'h100C,
    parameter int          POLL_DELAY = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic [31:0]              cq_araddr,
    output logic [7:0]               cq_arlen,
    output logic [2:0]               cq_arsize,
    output logic [1:0]               cq_arburst,
    output logic                     cq_arvalid,
    input  logic                     cq_arready,
    input  logic [127:0]             cq_rdata,
    input  logic [1:0]               cq_rresp,
    input  logic                     cq_rlast,
    input  logic                     cq_rvalid,
    output logic                     cq_rready,
    output logic [31:0]              db_awaddr,
    output logic                     db_awvalid,
    input  logic                     db_awready,
    output logic [31:0]              db_wdata,
    output logic [3:0]               db_wstrb,
    output logic                     db_wvalid,
    input  logic                     db_wready,
    input  logic [1:0]               db_bresp,
    input  logic                     db_bvalid,
    output logic                     db_bready,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic [15:0]              cpl_cid,
    output logic [14:0]              cpl_status,
    output logic [$clog2(DEPTH)-1:0] sq_head,
    output logic [$clog2(DEPTH)-1:0] cq_head
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, AR, R, CPL, DB, B
`ifdef CQ_POLL_BACKOFF_EN
        , WAIT
`endif
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            exp_phase;
    logic            aw_done;
    logic            w_done;
    logic [IW-1:0]   entry_sqh;
    logic [IW-1:0]   head_nxt;
    logic            beat_match;
    logic            aw_ok;
    logic            w_ok;

`ifdef CQ_POLL_BACKOFF_EN
    localparam int BW = $clog2(POLL_DELAY + 1);
    logic [BW-1:0]   bcnt;
`endif

    // Response fields that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{cq_rlast, db_bresp, cq_rdata[63:0], cq_rdata[95:64+IW]};

    assign head_nxt   = cq_head + IW'(1);
    assign beat_match = (cq_rresp == 2'b00) && (cq_rdata[112] == exp_phase);
    assign aw_ok      = aw_done || (db_awvalid && db_awready);
    assign w_ok       = w_done  || (db_wvalid  && db_wready);

    assign cq_araddr  = CQ_BASE + {{(32-IW-4){1'b0}}, cq_head, 4'b0000};
    assign cq_arlen   = 8'd0;
    assign cq_arsize  = 3'd4;
    assign cq_arburst = 2'd1;
    assign cq_arvalid = (state == AR);
    assign cq_rready  = (state == R);
    assign cpl_valid  = (state == CPL);
    assign db_awaddr  = DB_ADDR;
    assign db_wdata   = {{(32-IW){1'b0}}, head_nxt};
    assign db_wstrb   = 4'hF;
    assign db_awvalid = (state == DB) && !aw_done;
    assign db_wvalid  = (state == DB) && !w_done;
    assign db_bready  = (state == B);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = AR;
            AR:   if (cq_arready) state_n = R;
            R: begin
                if (cq_rvalid) begin
                    if (beat_match) begin
                        state_n = CPL;
                    end else begin
`ifdef CQ_POLL_BACKOFF_EN
                        state_n = WAIT;
`else
                        state_n = AR;
`endif
                    end
                end
            end
`ifdef CQ_POLL_BACKOFF_EN
            WAIT: if (bcnt == BW'(POLL_DELAY - 1)) state_n = AR;
`endif
            CPL:  if (cpl_ready) state_n = DB;
            // Address and data may complete in either order or together.
            DB:   if (aw_ok && w_ok) state_n = B;
            B:    if (db_bvalid) state_n = AR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cq_head    <= '0;
            sq_head    <= '0;
            exp_phase  <= 1'b1;
            cpl_cid    <= '0;
            cpl_status <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            if (state == R && cq_rvalid && beat_match) begin
                cpl_cid    <= cq_rdata[111:96];
                cpl_status <= cq_rdata[127:113];
            end
            if (state == CPL && cpl_ready) begin
                sq_head <= entry_sqh;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (db_awvalid && db_awready) aw_done <= 1'b1;
            if (db_wvalid && db_wready)   w_done  <= 1'b1;
            // The response code is ignored: the head always advances.
            if (state == B && db_bvalid) begin
                cq_head <= head_nxt;
                if (cq_head == IW'(DEPTH - 1)) exp_phase <= ~exp_phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == R && cq_rvalid && beat_match) begin
            entry_sqh <= cq_rdata[64 +: IW];
        end
    end

`ifdef CQ_POLL_BACKOFF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bcnt <= '0;
        end else if (state == WAIT) begin
            bcnt <= bcnt + BW'(1);
        end else begin
            bcnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_cq_poller.sv
// Bench for cq_poller: AXI memory/doorbell/host responders, an event-level model of the
// CQ walk checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_cq_poller;
    localparam logic [31:0] CQ_BASE    = 32'h20400;
    localparam int          DEPTH      = 16;
    localparam logic [31:0] DB_ADDR    = 32'h100C;
    localparam int          POLL_DELAY = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [31:0]  cq_araddr;
    logic [7:0]   cq_arlen;
    logic [2:0]   cq_arsize;
    logic [1:0]   cq_arburst;
    logic         cq_arvalid;
    logic         cq_arready = 1'b0;
    logic [127:0] cq_rdata = '0;
    logic [1:0]   cq_rresp = 2'b00;
    logic         cq_rlast = 1'b0;
    logic         cq_rvalid = 1'b0;
    logic         cq_rready;
    logic [31:0]  db_awaddr;
    logic         db_awvalid;
    logic         db_awready = 1'b0;
    logic [31:0]  db_wdata;
    logic [3:0]   db_wstrb;
    logic         db_wvalid;
    logic         db_wready = 1'b0;
    logic [1:0]   db_bresp = 2'b00;
    logic         db_bvalid = 1'b0;
    logic         db_bready;
    logic         cpl_valid;
    logic         cpl_ready = 1'b0;
    logic [15:0]  cpl_cid;
    logic [14:0]  cpl_status;
    logic [3:0]   sq_head;
    logic [3:0]   cq_head;

    cq_poller #(.CQ_BASE(CQ_BASE), .DEPTH(DEPTH), .DB_ADDR(DB_ADDR), .POLL_DELAY(POLL_DELAY)) dut (
        .clk(clk), .rstn(rstn),
        .cq_araddr(cq_araddr), .cq_arlen(cq_arlen), .cq_arsize(cq_arsize), .cq_arburst(cq_arburst),
        .cq_arvalid(cq_arvalid), .cq_arready(cq_arready),
        .cq_rdata(cq_rdata), .cq_rresp(cq_rresp), .cq_rlast(cq_rlast),
        .cq_rvalid(cq_rvalid), .cq_rready(cq_rready),
        .db_awaddr(db_awaddr), .db_awvalid(db_awvalid), .db_awready(db_awready),
        .db_wdata(db_wdata), .db_wstrb(db_wstrb), .db_wvalid(db_wvalid), .db_wready(db_wready),
        .db_bresp(db_bresp), .db_bvalid(db_bvalid), .db_bready(db_bready),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid), .cpl_status(cpl_status),
        .sq_head(sq_head), .cq_head(cq_head)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Memory image of the completion queue.
    logic        mem_ph [DEPTH];
    logic [15:0] mem_cid[DEPTH];
    logic [15:0] mem_sqh[DEPTH];
    logic [14:0] mem_st [DEPTH];

    int         ar_delay = 0, aw_delay = 0, w_delay = 0, cpl_delay = 0;
    logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;

    // Model of the walk: head, expected phase, pending completion.
    int          m_head, m_sq, m_sqh;
    logic        m_phase;
    bit          m_pend, rd_out;
    logic [15:0] m_cid;
    logic [14:0] m_st;

    int n_ar, n_cpl, n_b, cyc;
    int aw_tx, w_tx, cpl_len, aw_len, w_len;
    logic [31:0] q_araddr[$];
    int          q_arcyc[$];
    logic [15:0] q_cid[$];
    logic [14:0] q_st[$];
    logic [31:0] q_wdata[$];
    int          q_cpllen[$], q_awlen[$], q_wlen[$];

    bit   hs_ar, hs_r, hs_aw, hs_w, hs_b;
    int   ar_idx;
    bit   prev_ar_stall;
    logic [31:0] prev_araddr;

    function automatic logic [127:0] entry(input int i);
        return {mem_st[i], mem_ph[i], mem_cid[i], 16'h0000, mem_sqh[i], 32'hCAFE0000, 32'(i)};
    endfunction

    // Compare process: everything sampled on the falling edge describes the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
            if (!rstn) begin
                m_head = 0; m_phase = 1'b1; m_sq = 0; m_pend = 0; rd_out = 0;
                aw_tx = 0; w_tx = 0; cpl_len = 0; aw_len = 0; w_len = 0; prev_ar_stall = 0;
            end else begin
                check("cq_head", cq_head, m_head);
                check("sq_head", sq_head, m_sq);
                check("cpl_valid", cpl_valid, m_pend);
                if (m_pend) check("db_idle_in_cpl", db_awvalid | db_wvalid, 0);
                if (prev_ar_stall) check("ar_hold", {cq_arvalid, cq_araddr}, {1'b1, prev_araddr});
                if (cq_arvalid) begin
                    check("araddr", cq_araddr, CQ_BASE + 32'(m_head * 16));
                    check("ar_const", {cq_arlen, cq_arsize, cq_arburst}, {8'd0, 3'd4, 2'd1});
                    check("ar_single", {m_pend, rd_out}, 0);
                    if (cq_arready) begin
                        hs_ar = 1; rd_out = 1; n_ar++;
                        q_araddr.push_back(cq_araddr);
                        q_arcyc.push_back(cyc);
                        ar_idx = int'((cq_araddr - CQ_BASE) >> 4) % DEPTH;
                    end
                end
                prev_ar_stall = cq_arvalid && !cq_arready;
                prev_araddr   = cq_araddr;
                if (cpl_valid) begin
                    cpl_len++;
                    check("cpl_fields", {cpl_cid, cpl_status}, {m_cid, m_st});
                    if (cpl_ready) begin
                        n_cpl++;
                        q_cid.push_back(cpl_cid);
                        q_st.push_back(cpl_status);
                        q_cpllen.push_back(cpl_len);
                        cpl_len = 0; m_sq = m_sqh; m_pend = 0;
                    end
                end
                if (cq_rvalid && cq_rready) begin
                    hs_r = 1; rd_out = 0;
                    if (cq_rresp == 2'b00 && cq_rdata[112] == m_phase) begin
                        m_pend = 1;
                        m_cid  = cq_rdata[111:96];
                        m_st   = cq_rdata[127:113];
                        m_sqh  = int'(cq_rdata[79:64]) % DEPTH;
                    end
                end
                if (db_awvalid) begin
                    aw_len++;
                    if (db_awready) begin
                        hs_aw = 1; aw_tx++;
                        check("awaddr", db_awaddr, DB_ADDR);
                    end
                end
                if (db_wvalid) begin
                    w_len++;
                    if (db_wready) begin
                        hs_w = 1; w_tx++;
                        check("wdata", db_wdata, 32'((m_head + 1) % DEPTH));
                        check("wstrb", db_wstrb, 4'hF);
                        q_wdata.push_back(db_wdata);
                    end
                end
                if (db_bready) check("writes_before_b", {aw_tx, w_tx}, {32'd1, 32'd1});
                if (db_bvalid && db_bready) begin
                    hs_b = 1; n_b++;
                    q_awlen.push_back(aw_len);
                    q_wlen.push_back(w_len);
                    aw_tx = 0; w_tx = 0; aw_len = 0; w_len = 0;
                    m_head = (m_head + 1) % DEPTH;
                    if (m_head == 0) m_phase = !m_phase;
                end
            end
        end
    end

    // AXI memory, doorbell target and host sink.
    initial begin
        int ar_wait, aw_wait, w_wait, cpl_wait;
        bit aw_got, w_got;
        ar_wait = 0; aw_wait = 0; w_wait = 0; cpl_wait = 0; aw_got = 0; w_got = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                cq_arready = 0; cq_rvalid = 0; cq_rlast = 0; cq_rresp = 0;
                db_awready = 0; db_wready = 0; db_bvalid = 0; db_bresp = 0; cpl_ready = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; cpl_wait = 0; aw_got = 0; w_got = 0;
            end else begin
                if (cq_arvalid) begin cq_arready = (ar_wait >= ar_delay); ar_wait++; end
                else begin cq_arready = 0; ar_wait = 0; end
                if (hs_ar) begin
                    cq_rvalid = 1; cq_rlast = 1; cq_rresp = cfg_rresp; cq_rdata = entry(ar_idx);
                end else if (hs_r) begin
                    cq_rvalid = 0; cq_rlast = 0;
                end
                if (cpl_valid) begin cpl_ready = (cpl_wait >= cpl_delay); cpl_wait++; end
                else begin cpl_ready = 0; cpl_wait = 0; end
                if (db_awvalid) begin db_awready = (aw_wait >= aw_delay); aw_wait++; end
                else begin db_awready = 0; aw_wait = 0; end
                if (db_wvalid) begin db_wready = (w_wait >= w_delay); w_wait++; end
                else begin db_wready = 0; w_wait = 0; end
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got = 1;
                if (hs_b) begin
                    db_bvalid = 0; aw_got = 0; w_got = 0;
                end else if (aw_got && w_got) begin
                    db_bvalid = 1; db_bresp = cfg_bresp;
                end
            end
        end
    end

    task automatic set_entry(input int i, input logic ph, input logic [15:0] cid,
                             input logic [15:0] sqh, input logic [14:0] st);
        mem_ph[i] = ph; mem_cid[i] = cid; mem_sqh[i] = sqh; mem_st[i] = st;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) set_entry(i, 1'b0, 16'hFFFF, 16'h0, 15'h0);
    endtask

    // Holds reset for two edges, checks the reset state, then releases.
    task automatic do_reset(input string nm);
        @(posedge clk); #3;
        rstn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check({nm, "_rst_outputs"}, {cq_arvalid, cq_rready, cpl_valid, db_awvalid, db_wvalid,
              db_bready, cpl_cid, cpl_status, cq_head, sq_head}, 0);
        check({nm, "_rst_araddr"}, cq_araddr, 32'h20400);
        n_ar = 0; n_cpl = 0; n_b = 0;
        q_araddr.delete(); q_arcyc.delete(); q_cid.delete(); q_st.delete();
        q_wdata.delete(); q_cpllen.delete(); q_awlen.delete(); q_wlen.delete();
        @(posedge clk); #3;
        rstn = 1;
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0: return n_cpl;
            1: return n_b;
            2: return n_ar;
            default: return int'(cpl_valid);
        endcase
    endfunction

    task automatic wait_until(input string nm, input int which, input int target, input int budget);
        int k;
        k = 0;
        while (get_cnt(which) < target && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check({nm, "_reached"}, get_cnt(which) >= target, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        int exp_wd[17];
        int bad_addr, gap;
        exp_wd = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};

        // Single completion from entry 0.
        clear_mem();
        set_entry(0, 1'b1, 16'd5, 16'd1, 15'h0);
        do_reset("t1");
        wait_until("t1_cpl", 0, 1, 100);
        wait_until("t1_b", 1, 1, 100);
        idle(2);
        check("t1_araddr0", q_araddr.size() > 0 ? q_araddr[0] : 32'hx, 32'h20400);
        check("t1_cid", q_cid.size() > 0 ? q_cid[0] : 16'hx, 16'd5);
        check("t1_wdata", q_wdata.size() > 0 ? q_wdata[0] : 32'hx, 32'd1);
        check("t1_ch_lens", {q_awlen.size() > 0 ? q_awlen[0] : -1, q_wlen.size() > 0 ? q_wlen[0] : -1},
              {32'd1, 32'd1});
        check("t1_sq_head", sq_head, 4'd1);
        check("t1_cq_head", cq_head, 4'd1);

        // Stale entry 0: polling with no completion.
        clear_mem();
        set_entry(0, 1'b0, 16'd6, 16'd2, 15'h0);
        do_reset("t2");
        idle(80);
        check("t2_no_cpl", n_cpl, 0);
        check("t2_repolls", n_ar >= 3, 1);
        bad_addr = 0;
        foreach (q_araddr[i]) if (q_araddr[i] != 32'h20400) bad_addr++;
        check("t2_addr_all_entry0", bad_addr, 0);
        gap = q_arcyc.size() > 1 ? q_arcyc[1] - q_arcyc[0] : -1;
`ifdef CQ_POLL_BACKOFF_EN
        check("t2_ar_spacing", gap >= POLL_DELAY + 1, 1);
`else
        check("t2_ar_spacing", gap, 2);
`endif
        // Phase now matches but the slave returns SLVERR: still no completion.
        cfg_rresp = 2'b10;
        set_entry(0, 1'b1, 16'd7, 16'd3, 15'h0);
        idle(60);
        check("t2_err_no_cpl", n_cpl, 0);
        cfg_rresp = 2'b00;
        wait_until("t2_cpl", 0, 1, 100);
        check("t2_cid", q_cid.size() > 0 ? q_cid[0] : 16'hx, 16'd7);

        // Full lap with stalls, doorbell skew and error bresp; wrap then phase 0 accepted.
        clear_mem();
        for (int i = 0; i < DEPTH; i++)
            set_entry(i, 1'b1, 16'h100 + 16'(i), 16'(i * 3 + 17), (i == 3) ? 15'h1234 : 15'h0);
        cpl_delay = 10; aw_delay = 3; w_delay = 0; cfg_bresp = 2'b10;
        do_reset("t3");
        wait_until("t3_first", 0, 1, 200);
        set_entry(0, 1'b0, 16'h200, 16'd5, 15'h0);
        wait_until("t3_17", 0, 17, 2000);
        idle(60);
        check("t3_exactly17", n_cpl, 17);
        for (int k = 0; k < 17; k++)
            check("t3_wdata_seq", q_wdata.size() > k ? q_wdata[k] : 32'hx, 32'(exp_wd[k]));
        check("t3_cid17", q_cid.size() > 16 ? q_cid[16] : 16'hx, 16'h200);
        check("t3_status3", q_st.size() > 3 ? q_st[3] : 15'hx, 15'h1234);
        check("t3_cq_head", cq_head, 4'd1);
        check("t3_sq_head", sq_head, 4'd5);
        check("t3_cpl_held", q_cpllen.size() > 0 ? q_cpllen[0] : -1, 11);
        check("t3_aw_len", q_awlen.size() > 0 ? q_awlen[0] : -1, 4);
        check("t3_w_len", q_wlen.size() > 0 ? q_wlen[0] : -1, 1);
        cpl_delay = 0; aw_delay = 0; cfg_bresp = 2'b00;

        // Reset while a completion is stalled abandons it; the walk restarts at entry 0.
        clear_mem();
        set_entry(0, 1'b1, 16'h33, 16'd2, 15'h0);
        cpl_delay = 1000;
        do_reset("t4a");
        wait_until("t4_cpl_up", 3, 1, 100);
        set_entry(0, 1'b1, 16'h44, 16'd9, 15'h0);
        do_reset("t4b");
        cpl_delay = 0;
        wait_until("t4_cpl", 0, 1, 100);
        check("t4_araddr0", q_araddr.size() > 0 ? q_araddr[0] : 32'hx, 32'h20400);
        check("t4_cid", q_cid.size() > 0 ? q_cid[0] : 16'hx, 16'h44);
        idle(10);
        check("t4_sq_head", sq_head, 4'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

endmodule

// File: doc/cq_poller.md
CQ_POLLER -- requirements
Module: cq_poller

Interface
REQ-001 Parameter CQ_BASE, default 32'h20400, byte address of CQ entry 0 in buffer memory.
REQ-002 Parameter DEPTH, default 16, number of CQ entries; power of two.
REQ-003 Parameter DB_ADDR, default 32'h100C, CQ1 head doorbell register address.
REQ-004 Parameter POLL_DELAY, default 16, backoff cycles; used only when the macro is defined.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rstn  in  1  reset, synchronous and active-low.
REQ-007 cq_araddr  out  32  CQ entry read address.
REQ-008 cq_arlen/arsize/arburst  out  8/3/2  constants 0/4/1 (single 16B beat, INCR).
REQ-009 cq_arvalid/cq_arready  out/in  1/1  read address handshake.
REQ-010 cq_rdata  in  128  CQ entry: [79:64] SQ head, [111:96] CID, [112] phase, [127:113] status.
REQ-011 cq_rresp/cq_rlast  in  2/1  read response and last flag.
REQ-012 cq_rvalid/cq_rready  in/out  1/1  read data handshake.
REQ-013 db_awaddr/db_awvalid/db_awready  out/out/in  32/1/1  AXI-lite doorbell address channel.
REQ-014 db_wdata/db_wstrb/db_wvalid/db_wready  out/out/out/in  32/4/1/1  doorbell data channel.
REQ-015 db_bresp/db_bvalid/db_bready  in/in/out  2/1/1  doorbell response channel.
REQ-016 cpl_valid/cpl_ready  out/in  1/1  completion handshake toward host write-response logic.
REQ-017 cpl_cid/cpl_status  out  16/15  CID and status of the completed command.
REQ-018 sq_head  out  $clog2(DEPTH)  SQ head consumed by the controller; feeds the SQ-full check.
REQ-019 cq_head  out  $clog2(DEPTH)  current CQ head index.

Function
REQ-020 FSM states SHALL be IDLE, AR, R, WAIT, CPL, DB, B.
REQ-021 IDLE SHALL go to AR one cycle after reset release.
REQ-022 AR: cq_arvalid=1 and cq_araddr=CQ_BASE+cq_head*16, both held stable until cq_arready; handshake -> R.
REQ-023 R: cq_rready=1; on cq_rvalid, a match (cq_rresp==0 and rdata[112]==exp_phase) SHALL latch the entry and go to CPL.
REQ-024 R: a non-matching beat (wrong phase or rresp!=0) SHALL go to WAIT when the macro is defined, else to AR.
REQ-025 CPL: cpl_valid=1 with latched cpl_cid/cpl_status held until cpl_ready; on handshake, sq_head <= rdata[79:64] truncated to $clog2(DEPTH) bits, go to DB.
REQ-026 DB: db_awvalid and db_wvalid SHALL assert together; each deasserts after its own handshake; exit to B once both have completed, in any order or in the same cycle.
REQ-027 DB values: db_awaddr=DB_ADDR, db_wdata=(cq_head+1)%DEPTH zero-extended, db_wstrb=4'hF.
REQ-028 B: db_bready=1; on db_bvalid, cq_head <= (cq_head+1)%DEPTH; on wrap from DEPTH-1 to 0, exp_phase SHALL toggle; go to AR.
REQ-029 db_bresp SHALL be ignored; the head still advances.
REQ-030 At most one read and one doorbell transaction SHALL be outstanding; entries complete strictly in CQ order.
REQ-031 cpl_status!=0 SHALL be passed through unchanged; no retry.

Reset
REQ-032 While rstn is low at a clock edge: state=IDLE, cq_head=0, sq_head=0, exp_phase=1, backoff counter=0, all valid/ready outputs 0, cpl_cid/cpl_status=0.
REQ-033 Reset mid-transaction SHALL abandon it immediately; the environment resets its AXI peers in the same cycle.

Configuration
REQ-034 With CQ_POLL_BACKOFF_EN defined: WAIT SHALL count POLL_DELAY cycles, then go to AR (POLL_DELAY+1 cycles from mismatch to next cq_arvalid).
REQ-035 Without CQ_POLL_BACKOFF_EN: WAIT and its counter SHALL be absent; mismatch goes to AR on the next cycle.

Verification
REQ-036 After reset, memory entry 0 has phase=1, CID=5, SQ head=1 -> araddr 0x20400, cpl_cid=5, sq_head=1, doorbell wdata=1 at 0x100C.
REQ-037 Entry 0 has phase=0 -> repeated reads of 0x20400 with no cpl_valid; with macro, ar spacing is >=POLL_DELAY+1 cycles.
REQ-038 16 valid entries (phase=1) then entry 0 rewritten with phase=0 -> cq_head wraps to 0, exp_phase=0, the 17th completion is accepted, doorbell wdata sequence 1..15,0,1.
REQ-039 cpl_ready held low 10 cycles -> cpl_valid and cpl_cid stay stable, no doorbell until handshake.
REQ-040 db_wready granted 3 cycles before db_awready, and separately both in the same cycle -> exactly one write per channel, then bready.
